// File: rtl/lfsr_arb_ctrl_if.sv
// Request/grant and output-word bundle for the LFSR arbiter.
// The master drives requests and seeds; the slave (the arbiter) returns grants and words.
interface lfsr_arb_ctrl_if;
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    logic       seed_ld;
    logic [3:0] seed;
    logic [1:0] grant;
    logic       busy;
    logic       out_valid;
    logic [3:0] out_data;
    logic [1:0] done;

    modport master (
        output req, len0, len1, seed_ld, seed,
        input  grant, busy, out_valid, out_data, done
    );

    modport slave (
        input  req, len0, len1, seed_ld, seed,
        output grant, busy, out_valid, out_data, done
    );
endinterface

// File: rtl/lfsr_arb_ctrl.sv
// Two-requester round-robin arbiter that lends one shared 4-bit Fibonacci LFSR
// to the winner for a burst of len words (len 0 = 16 words).
module lfsr_arb_ctrl (
    input  logic           clk,
    input  logic           rst,
    lfsr_arb_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t     state_q, state_d;
    logic [3:0] lfsr_q, lfsr_d;
    logic [4:0] cnt_q, cnt_d;
    logic [1:0] owner_q, owner_d;
    // prio_q = 1 means requester 1 wins a tie.
    logic       prio_q, prio_d;

    logic       win1;
    logic [3:0] win_len;
    logic [3:0] lfsr_step;

    assign win1      = bus.req[1] && (!bus.req[0] || prio_q);
    assign win_len   = win1 ? bus.len1 : bus.len0;
    assign lfsr_step = {lfsr_q[3] ^ lfsr_q[0], lfsr_q[3:1]};

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        unique case (state_q)
            StIdle: begin
                // An all-zero seed would lock the LFSR, so substitute 1000.
                if (bus.seed_ld) begin
                    lfsr_d = (bus.seed == 4'b0000) ? 4'b1000 : bus.seed;
                end
                if (|bus.req) begin
                    owner_d = win1 ? 2'b10 : 2'b01;
                    cnt_d   = {(win_len == 4'd0), win_len};
                    prio_d  = !win1;
                    state_d = StRun;
                end
            end
            StRun: begin
                lfsr_d = lfsr_step;
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            lfsr_q  <= 4'b1000;
            cnt_q   <= 5'd0;
            owner_q <= 2'b00;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
        end
    end

    assign bus.grant     = (state_q == StRun) ? owner_q : 2'b00;
    assign bus.busy      = (state_q == StRun) || (state_q == StDone);
    assign bus.out_valid = (state_q == StRun);
    assign bus.out_data  = lfsr_q;
    assign bus.done      = (state_q == StDone) ? owner_q : 2'b00;

endmodule

// File: doc/lfsr_arb_ctrl.md
LFSR_ARB_CTRL -- requirements
Module: lfsr_arb_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  synchronous reset, active-high.
REQ-003 req  input  2  per-requester request; bit i = requester i.
REQ-004 len0  input  4  requester 0 burst length in words; 0 encodes 16.
REQ-005 len1  input  4  requester 1 burst length in words; 0 encodes 16.
REQ-006 seed_ld  input  1  load seed into LFSR; honoured only in IDLE.
REQ-007 seed  input  4  seed value as {q1,q2,q3,q4}.
REQ-008 grant  output  2  one-hot owner of LFSR during RUN; 00 otherwise.
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 out_valid  output  1  high when out_data carries a word for the granted requester.
REQ-011 out_data  output  4  LFSR state {q1,q2,q3,q4}.
REQ-012 done  output  2  one-cycle pulse on the bit of the requester whose burst just finished.

Function
REQ-013 The block SHALL contain one 4-bit Fibonacci LFSR: on step, q1<=q1^q4, q2<=q1, q3<=q2, q4<=q3.
REQ-014 The LFSR SHALL step only in RUN, once per cycle; it holds in IDLE and DONE.
REQ-015 FSM states SHALL be IDLE, RUN, DONE; no other states.
REQ-016 IDLE->RUN when any req bit is 1; winner registered into grant and its len captured into a 5-bit counter (0 -> 16).
REQ-017 Arbitration SHALL be round-robin: single requester wins outright; when both request, the one not served last wins; after reset, requester 0 has priority.
REQ-018 In RUN, out_valid=1 and out_data=current LFSR state every cycle; counter decrements per word.
REQ-019 RUN->DONE in the cycle after the last word (counter reaches 0); burst of N words SHALL occupy exactly N RUN cycles.
REQ-020 DONE SHALL last one cycle: done[winner]=1, grant=00, out_valid=0, then ->IDLE.
REQ-021 First out_valid SHALL appear the cycle after req is sampled in IDLE (1-cycle grant latency).
REQ-022 req, len0/len1 SHALL be ignored outside IDLE; deasserting req mid-burst does not shorten it.
REQ-023 seed_ld in IDLE SHALL load seed next cycle; seed 0000 SHALL load 1000 instead (lockup avoidance).
REQ-024 seed_ld together with req in IDLE: seed SHALL load and the grant is taken that same edge; first word is the loaded seed.
REQ-025 seed_ld outside IDLE SHALL be ignored.
REQ-026 LFSR state SHALL persist across bursts (next burst continues the sequence).
REQ-027 Sequence from 1000 SHALL be period 15: 1000,1100,1110,1111,0111,1011,0101,1010,1101,0110,0011,1001,0100,0010,0001,1000.

Reset
REQ-028 rst SHALL force: state IDLE, LFSR=1000, grant=00, busy=0, out_valid=0, out_data=1000, done=00, counter=0, round-robin priority=requester 0.
REQ-029 rst asserted mid-RUN SHALL abort the burst on the next edge with no done pulse.
REQ-030 rst SHALL dominate seed_ld and req in the same cycle.

Verification
REQ-031 Reset, req=01, len0=3 -> grant=01 for 3 cycles, out_data 1000,1100,1110, then done=01 one cycle, IDLE.
REQ-032 req=11 held, len0=len1=2 after reset -> requester 0 served (1000,1100), then requester 1 (1110,1111), then requester 0 again (0111,1011).
REQ-033 Idle seed_ld with seed=0101, then req=10, len1=2 -> out_data 0101,1010; seed=0000 loads -> first word 1000.
REQ-034 len0=0 -> exactly 16 words; words 1 and 16 both 1000 (period-15 wrap).
REQ-035 rst asserted at third word of a 5-word burst -> next cycle grant=00, out_valid=0, out_data=1000, no done pulse.
REQ-036 seed_ld and req changes during RUN -> no effect on out_data sequence or burst length.
